lfsr_rand_server: RTL
=====================

Name: lfsr_rand_server

Overview:
- Owns one 16-bit Galois-style LFSR and shares it among NUM_REQ requesters; each granted request consumes exactly one word.
- Sequences the generator: seed load, zero-seed guard, warm-up stepping, then round-robin service.
- Consumers are the hand-gesture pipeline blocks that need dither/noise: overlay jitter, test-pattern noise, sampling decimation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WARMUP_CYCLES, 16, LFSR steps after seed load before service (0 = serve immediately).
- SEED_DEFAULT, 16'hACE1, seed used after reset and substituted for an all-zero seed.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- seed_valid_in  input  1  load seed_in this cycle (always accepted)
- seed_in  input  16  new seed
- req_in  input  NUM_REQ  per-requester request, held high until granted
- gnt_out  output  NUM_REQ  one-hot grant, combinational, at most one bit set
- rand_out  output  16  current LFSR word; valid to the requester whose gnt_out bit is high
- busy_out  output  1  high while not in SERVE
- seed_zero_out  output  1  registered 1-cycle pulse: last loaded seed was zero and was replaced

Behaviour:
- LFSR step: next = {s[15]^s[14], s[13:2], s[15]^s[1], s[0], s[15]}. The all-zero state is a lock-up and must never be loaded.
- Reset (async assert, sync release):
  - lfsr = SEED_DEFAULT, fsm = WARMUP (SERVE if WARMUP_CYCLES==0), warm counter = 0, rr pointer = 0.
  - gnt_out = 0, busy_out = 1 (0 if WARMUP_CYCLES==0), seed_zero_out = 0, rand_out = SEED_DEFAULT.
- FSM states: WARMUP, SERVE.
- WARMUP:
  - LFSR steps every cycle; counter increments; gnt_out = 0.
  - After WARMUP_CYCLES steps, go to SERVE on that edge.
  - Counter width is $clog2(WARMUP_CYCLES+1).
- SERVE:
  - gnt_out = round-robin pick among req_in bits, searching upward from rr pointer with wrap.
  - On an edge with a grant to index i: LFSR steps once; pointer <= (i+1) mod NUM_REQ.
  - No grant means no step; the word is held.
- Seed load (any state), with priority over everything:
  - gnt_out forced to 0 that cycle.
  - On the edge: lfsr <= (seed_in==0) ? SEED_DEFAULT : seed_in; counter <= 0; fsm <= WARMUP (SERVE if WARMUP_CYCLES==0); seed_zero_out <= (seed_in==0).
  - Pointer is not reset.
- Reset mid-warmup or mid-service: all in-flight state is discarded and the reset values apply.
- A requester that holds req after being granted is granted again only when its turn comes round; no starvation.
- busy_out = (fsm != SERVE), combinational from the state register.

Optional Feature:
- Macro: LFSR_FREE_RUN_EN.
- Defined: in SERVE the LFSR steps every cycle whether or not a grant occurs. Words become time-dependent, and a grant still returns the current word.
- Undefined: the LFSR steps only on grants, so the word sequence depends only on seed and grant count.
- Arbitration and seed handling are identical in both builds.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W = 16 and the lfsr_word_t typedef.
  - SEED_DEFAULT_C.
  - enum srv_state_t {WARMUP, SERVE}.
  - function lfsr_next(lfsr_word_t) implementing the step.
- Sub-module rr_arbiter (NUM_REQ param; inputs req, ptr, enable; output one-hot gnt, index) is natural and reusable.
- The FSM and LFSR register stay in lfsr_rand_server.

Test Plan:
- WARMUP_CYCLES=0, seed 16'h0001, req_in=4'b0001 held → gnt_out[0] every cycle, rand_out 0001, 0002, 0004, 0008 on successive cycles.
- Seed 16'h8000, one grant → rand_out 8000 at grant, 8005 on the next cycle.
- Seed 16'h0000 → seed_zero_out pulses once, then after warm-up the first granted word equals SEED_DEFAULT stepped 16 times (compare against the lfsr_next model).
- req_in=4'b1111, pointer 0 → grants to indices 0, 1, 2, 3, 0; then req_in=4'b0101 → 2, 0, 2.
- WARMUP_CYCLES=16: seed_valid_in together with active req in SERVE → gnt_out=0 that cycle, busy_out high for exactly 16 cycles, no grants until SERVE.
- rst_n_in pulsed low mid-warmup, asynchronously between edges → outputs reach their reset values immediately; the warm-up restarts from SEED_DEFAULT after release.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR word type, default seed, server states and the LFSR step function
package lfsr_pkg;
  localparam int LFSR_W = 16;
  typedef logic [LFSR_W-1:0] lfsr_word_t;
  localparam lfsr_word_t SEED_DEFAULT_C = 16'hACE1;
  typedef enum logic {WARMUP, SERVE} srv_state_t;
  function automatic lfsr_word_t lfsr_next(lfsr_word_t s);
    return {s[15] ^ s[14], s[13:2], s[15] ^ s[1], s[0], s[15]};
  endfunction
endpackage

// File: rtl/lfsr_rand_server_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick searching upward from ptr with wrap; ports req/ptr/enable in, gnt/idx out
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (enable && req[(int'(ptr) + k) % NUM_REQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        idx = PW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/lfsr_rand_server.sv
// lfsr_rand_server: one 16-bit Galois LFSR shared round-robin among NUM_REQ requesters.
// Ports: clk_in, rst_n_in (async active-low), seed_valid_in/seed_in (seed load),
// req_in/gnt_out (request / one-hot grant), rand_out (current word), busy_out (not serving),
// seed_zero_out (pulse when a zero seed was replaced).
// Define LFSR_FREE_RUN_EN to step the LFSR every SERVE cycle instead of only on grants.
module lfsr_rand_server
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WARMUP_CYCLES = 16,
  parameter lfsr_word_t SEED_DEFAULT = SEED_DEFAULT_C
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               seed_valid_in,
  input  logic [15:0]        seed_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] gnt_out,
  output logic [15:0]        rand_out,
  output logic               busy_out,
  output logic               seed_zero_out
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam srv_state_t INIT_ST = (WARMUP_CYCLES == 0) ? SERVE : WARMUP;
  srv_state_t st, st_nx;
  lfsr_word_t lfsr, lfsr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] ptr, ptr_nx, idx;
  logic any;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req(req_in),
    .ptr(ptr),
    .enable(st == SERVE && !seed_valid_in),
    .gnt(gnt_out),
    .idx(idx)
  );
  assign any = |gnt_out;
  assign rand_out = lfsr;
  assign busy_out = st != SERVE;
  always_comb begin
    lfsr_nx = lfsr;
    cnt_nx = cnt;
    st_nx = st;
    ptr_nx = ptr;
    if (seed_valid_in) begin
      lfsr_nx = (seed_in == '0) ? SEED_DEFAULT : seed_in;
      cnt_nx = '0;
      st_nx = INIT_ST;
    end else if (st == WARMUP) begin
      lfsr_nx = lfsr_next(lfsr);
      cnt_nx = cnt + CW'(1);
      st_nx = (int'(cnt) == WARMUP_CYCLES - 1) ? SERVE : WARMUP;
    end else begin
`ifdef LFSR_FREE_RUN_EN
      lfsr_nx = lfsr_next(lfsr);
`else
      lfsr_nx = any ? lfsr_next(lfsr) : lfsr;
`endif
      ptr_nx = !any ? ptr : (int'(idx) == NUM_REQ - 1) ? '0 : idx + PW'(1);
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st <= INIT_ST;
      lfsr <= SEED_DEFAULT;
      cnt <= '0;
      ptr <= '0;
      seed_zero_out <= 1'b0;
    end else begin
      st <= st_nx;
      lfsr <= lfsr_nx;
      cnt <= cnt_nx;
      ptr <= ptr_nx;
      seed_zero_out <= seed_valid_in && seed_in == '0;
    end
  end
endmodule
